// File: rtl/wb_burst_ram_slave.sv
// Wishbone B3 slave backed by an on-chip word array: classic cycles, optional wait states, ERR on out-of-range.
// Define WB_BURST_EN to compile in incrementing/wrapping burst support (cti=010, bte linear/wrap4/8/16).
module wb_burst_ram_slave #(
    parameter int Dw          = 32,
    parameter int Aw          = 10,
    parameter int MEM_WORDS   = 768,
    parameter int WAIT_STATES = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [Dw-1:0]   sa_dat_i,
    input  logic [Dw/8-1:0] sa_sel_i,
    input  logic [Aw-1:0]   sa_addr_i,
    input  logic            sa_cyc_i,
    input  logic            sa_stb_i,
    input  logic            sa_we_i,
    input  logic [2:0]      sa_cti_i,
    input  logic [1:0]      sa_bte_i,
    output logic [Dw-1:0]   sa_dat_o,
    output logic            sa_ack_o,
    output logic            sa_err_o,
    output logic            sa_rty_o
);
    localparam int              SELw      = Dw / 8;
    localparam logic [Aw:0]     MEM_LIM   = (Aw+1)'(MEM_WORDS);
    localparam logic [1:0]      WAIT_LAST = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WAIT        = 3'd1,
        S_CLASSIC_ACK = 3'd2,
        S_BURST       = 3'd3,
        S_ERR         = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [Aw-1:0]   r_cnt;
    logic [Aw-1:0]   w_cnt_nxt;
    logic [1:0]      r_wait;
    logic [1:0]      w_wait_nxt;
    logic            r_burst;
    logic            w_burst_nxt;
    logic [Dw-1:0]   r_mem [MEM_WORDS];
    logic [Dw-1:0]   r_dat;
    logic            w_req;
    logic            w_addr_oor;
    logic            w_is_burst_req;
    logic            w_ack;
    logic            w_err;
    logic            w_wr;
    logic            w_rd_load;

    assign w_req      = sa_cyc_i & sa_stb_i;
    assign w_addr_oor = ({1'b0, sa_addr_i} >= MEM_LIM);

`ifdef WB_BURST_EN
    logic [Aw:0] w_beat;

    // Wrap modes cycle the low 2/3/4 bits and keep the rest; linear carries into bit Aw so overflow is visible.
    function automatic logic [Aw:0] beat_next(input logic [Aw-1:0] cnt, input logic [1:0] bte);
        logic [Aw:0] nxt;
        nxt = {1'b0, cnt};
        case (bte)
            2'b00:   nxt = {1'b0, cnt} + {{Aw{1'b0}}, 1'b1};
            2'b01:   nxt[1:0] = cnt[1:0] + 2'd1;
            2'b10:   nxt[2:0] = cnt[2:0] + 3'd1;
            2'b11:   nxt[3:0] = cnt[3:0] + 4'd1;
            default: nxt = {1'b0, cnt};
        endcase
        return nxt;
    endfunction

    assign w_is_burst_req = (sa_cti_i == 3'b010);
`else
    logic w_unused_burst_ctl;

    assign w_is_burst_req     = 1'b0;
    assign w_unused_burst_ctl = &{1'b0, sa_cti_i, sa_bte_i};
`endif

    // Next-state, beat counter and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wait_nxt  = r_wait;
        w_burst_nxt = r_burst;
        w_ack       = 1'b0;
        w_err       = 1'b0;
`ifdef WB_BURST_EN
        w_beat      = beat_next(r_cnt, sa_bte_i);
`endif
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_cnt_nxt   = sa_addr_i;
                    w_burst_nxt = w_is_burst_req;
                    w_wait_nxt  = 2'd0;
                    if (w_addr_oor) begin
                        w_state_nxt = S_ERR;
                    end else if (WAIT_STATES > 0) begin
                        w_state_nxt = S_WAIT;
                    end else if (w_is_burst_req) begin
                        w_state_nxt = S_BURST;
                    end else begin
                        w_state_nxt = S_CLASSIC_ACK;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!sa_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_wait == WAIT_LAST) begin
                    w_state_nxt = r_burst ? S_BURST : S_CLASSIC_ACK;
                end else begin
                    w_wait_nxt = r_wait + 2'd1;
                end
            end
            S_CLASSIC_ACK: begin
                w_ack       = sa_cyc_i;
                w_state_nxt = S_IDLE;
            end
            S_ERR: begin
                w_err       = sa_cyc_i;
                w_state_nxt = S_IDLE;
            end
            S_BURST: begin
`ifdef WB_BURST_EN
                if (!sa_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else if (sa_stb_i) begin
                    w_ack = 1'b1;
                    if (sa_cti_i == 3'b111) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_beat >= MEM_LIM) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_cnt_nxt = w_beat[Aw-1:0];
                    end
                end else begin
                    w_state_nxt = S_BURST;
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_wr      = w_ack & sa_stb_i & sa_we_i;
    // Prefetch the word for the coming ACK cycle so read data is registered yet zero-latency.
    assign w_rd_load = ((w_state_nxt == S_CLASSIC_ACK) || (w_state_nxt == S_BURST)) &&
                       ({1'b0, w_cnt_nxt} < MEM_LIM);

    // State, beat counter and wait counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_wait  <= 2'd0;
            r_burst <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wait  <= w_wait_nxt;
            r_burst <= w_burst_nxt;
        end
    end

    // Byte-lane writes on acked write beats; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            for (int b = 0; b < SELw; b++) begin
                if (sa_sel_i[b]) begin
                    r_mem[r_cnt][b*8 +: 8] <= sa_dat_i[b*8 +: 8];
                end
            end
        end
    end

    // Read data register; holds between loads.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_dat <= '0;
        end else if (w_rd_load) begin
            r_dat <= r_mem[w_cnt_nxt];
        end
    end

    assign sa_dat_o = r_dat;
    assign sa_ack_o = w_ack;
    assign sa_err_o = w_err;
    assign sa_rty_o = 1'b0;

endmodule
